// File: rtl/output_layer_accumulator.sv
// -----------------------------------------------------------------------------
// output_layer_accumulator
//
// Output stage of the classifier. Streams one image of IMG_SIZE unsigned 8-bit
// pixels and multiply-accumulates each pixel against CLASSES signed 8-bit
// weights. When the image is complete, each accumulator is arithmetically
// shifted right by SHIFT and clamped to 0..255. The packed scores are then held
// behind a valid/ready handshake until the consumer takes them.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   pixel_valid_i   pixel beat valid
//   pixel_ready_o   a pixel beat is accepted this cycle (ACCUM only)
//   pixel_i         unsigned pixel value
//   weights_i       signed weight per class, sampled together with the pixel
//   result_o        saturated unsigned scores, packed [CLASSES-1:0][7:0]
//   result_valid_o  result vector valid
//   result_ready_i  consumer takes the result
//   busy_o          an image is partially accepted, or SCALE/HOLD is active
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACCUM | accepting pixel beats, one MAC per class per accepted beat
// ST_SCALE | single cycle: shift + saturate accumulators into result
// ST_HOLD  | result_valid high, waiting for result_ready
// -----------------------------------------------------------------------------
module output_layer_accumulator #(
  parameter int IMG_SIZE = 256,
  parameter int CLASSES  = 10,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pixel_valid_i,
  output logic                    pixel_ready_o,
  input  logic [7:0]              pixel_i,
  input  logic [CLASSES-1:0][7:0] weights_i,
  output logic [CLASSES-1:0][7:0] result_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(IMG_SIZE);
  localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(IMG_SIZE - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(255);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCALE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_q [CLASSES];
  logic signed [ACC_W-1:0] acc_d [CLASSES];
  logic [CLASSES-1:0][7:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;

  logic signed [16:0]      prod     [CLASSES];
  logic signed [ACC_W-1:0] prod_ext [CLASSES];
  logic signed [ACC_W-1:0] scaled   [CLASSES];
  logic [7:0]              sat      [CLASSES];
  logic                    beat_acc;

  // Ready is forced low while reset is asserted so no beat is taken during it.
  assign pixel_ready_o  = (state_q == ST_ACCUM) && !rst_i;
  assign beat_acc       = pixel_valid_i && pixel_ready_o;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = (state_q != ST_ACCUM) || (count_q != '0);

  // Pixel is zero-extended to 9 bits so the product is a true signed 9x8
  // multiply; the 17-bit result always holds the exact product.
  always_comb begin
    for (int c = 0; c < CLASSES; c++) begin
      prod[c]     = $signed({9'b0, pixel_i}) *
                    $signed({{9{weights_i[c][7]}}, weights_i[c]});
      prod_ext[c] = ACC_W'(prod[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < CLASSES; c++) begin
      scaled[c] = acc_q[c] >>> SHIFT;
      if (scaled[c][ACC_W-1]) begin
        sat[c] = 8'd0;
      end else if (scaled[c] > SAT_MAX) begin
        sat[c] = 8'hFF;
      end else begin
        sat[c] = scaled[c][7:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    for (int c = 0; c < CLASSES; c++) begin
      acc_d[c] = acc_q[c];
    end

    case (state_q)
      ST_ACCUM: begin
        if (beat_acc) begin
          for (int c = 0; c < CLASSES; c++) begin
            acc_d[c] = acc_q[c] + prod_ext[c];
          end
          if (count_q == LAST_BEAT) begin
            count_d = '0;
            state_d = ST_SCALE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_SCALE: begin
        for (int c = 0; c < CLASSES; c++) begin
          result_d[c] = sat[c];
        end
        result_valid_d = 1'b1;
        state_d        = ST_HOLD;
      end
      ST_HOLD: begin
        // result_q is intentionally left alone so the last scores stay visible.
        if (result_valid_q && result_ready_i) begin
          result_valid_d = 1'b0;
          count_d        = '0;
          for (int c = 0; c < CLASSES; c++) begin
            acc_d[c] = '0;
          end
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_ACCUM;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      for (int c = 0; c < CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      for (int c = 0; c < CLASSES; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

endmodule
